// File: rtl/hash_pkg.sv
// Shared types and sizing for the hash sequencer: FSM state encoding,
// default data widths and the bounty-buffer index width.
package hash_pkg;
  localparam int NONCE_W_DEF  = 32;
  localparam int BOUNTY_W_DEF = 24;
  localparam int IDX_W        = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_RESULT,
    S_DONE
  } state_t;
endpackage

// File: rtl/hash_sequencer_if.sv
// Start/done handshake between the sequencer (master) and the hash core (slave).
interface hash_sequencer_if
  import hash_pkg::*;
#(
  parameter int NONCE_W  = NONCE_W_DEF,
  parameter int BOUNTY_W = BOUNTY_W_DEF
);
  logic                hash_start;
  logic [NONCE_W-1:0]  nonce;
  logic [BOUNTY_W-1:0] bounty_out;
  logic                hash_done;
  logic                hash_hit;

  modport master (output hash_start, nonce, bounty_out, input hash_done, hash_hit);
  modport slave  (input hash_start, nonce, bounty_out, output hash_done, hash_hit);
endinterface

// File: rtl/hash_sequencer_nonce_counter.sv
// Per-entry nonce register: clears to zero, steps by one, and flags the
// terminal nonce so the sequencer can stop before the counter would wrap.
module nonce_counter
  import hash_pkg::*;
#(
  parameter int                 NONCE_W   = NONCE_W_DEF,
  parameter logic [NONCE_W-1:0] MAX_NONCE = {NONCE_W{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [NONCE_W-1:0] count,
  output logic               last
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == MAX_NONCE);
endmodule

// File: rtl/hash_sequencer.sv
// Walks the bounty buffer entry by entry, sweeping nonces through the hash
// core until a hit or exhaustion, and reports one result per entry.
module hash_sequencer
  import hash_pkg::*;
#(
  parameter int                 NONCE_W   = NONCE_W_DEF,
  parameter int                 BOUNTY_W  = BOUNTY_W_DEF,
  parameter logic [NONCE_W-1:0] MAX_NONCE = {NONCE_W{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IDX_W-1:0]    num_entradas,
  output logic [IDX_W-1:0]    rd_ptr,
  input  logic [BOUNTY_W-1:0] bounty,
  hash_sequencer_if.master    core,
  output logic                res_valid,
  output logic [IDX_W-1:0]    res_idx,
  output logic                res_found,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic                busy,
  output logic                fin
);
  state_t             state;
  logic [IDX_W-1:0]   last_idx;
  logic               hit_reg;
  logic [NONCE_W-1:0] nonce;
  logic               nonce_last;
  logic               nonce_clear;
  logic               nonce_inc;

  assign nonce_clear = (state == S_LATCH);
  assign nonce_inc   = (state == S_RESULT) && !hit_reg && !nonce_last;
  assign core.nonce  = nonce;

  nonce_counter #(
    .NONCE_W   (NONCE_W),
    .MAX_NONCE (MAX_NONCE)
  ) u_nonce (
    .clk   (clk),
    .reset (reset),
    .clear (nonce_clear),
    .inc   (nonce_inc),
    .count (nonce),
    .last  (nonce_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      rd_ptr          <= '0;
      core.bounty_out <= '0;
      core.hash_start <= 1'b0;
      res_idx         <= '0;
      res_nonce       <= '0;
      res_valid       <= 1'b0;
      res_found       <= 1'b0;
      busy            <= 1'b0;
      fin             <= 1'b0;
      last_idx        <= '0;
      hit_reg         <= 1'b0;
    end else begin
      core.hash_start <= 1'b0;
      res_valid       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            last_idx <= num_entradas;
            rd_ptr   <= '0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: state <= S_LATCH;
        S_LATCH: begin
          core.bounty_out <= bounty;
          core.hash_start <= 1'b1;
          state           <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // Result is registered here so res_valid lands one cycle after done.
          if (core.hash_done) begin
            hit_reg <= core.hash_hit;
            if (core.hash_hit || nonce_last) begin
              res_valid <= 1'b1;
              res_found <= core.hash_hit;
              res_nonce <= core.hash_hit ? nonce : MAX_NONCE;
              res_idx   <= rd_ptr;
            end
            state <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (hit_reg || nonce_last) begin
            if (rd_ptr == last_idx) begin
              busy  <= 1'b0;
              fin   <= 1'b1;
              state <= S_DONE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= S_LOAD;
            end
          end else begin
            core.hash_start <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (!start) begin
            fin   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_sequencer.sv
// Randomized bench: a behavioural core and buffer drive the sequencer and
// every run is compared against per-entry expectations derived from hit nonces.
module tb_hash_sequencer;
  localparam int NW = 32;
  localparam int BW = 24;
  localparam int MAXN = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    num_entradas;
  logic [1:0]    rd_ptr;
  logic [BW-1:0] bounty;
  logic          res_valid, res_found, busy, fin;
  logic [1:0]    res_idx;
  logic [NW-1:0] res_nonce;

  hash_sequencer_if #(.NONCE_W(NW), .BOUNTY_W(BW)) ifc ();

  hash_sequencer #(.NONCE_W(NW), .BOUNTY_W(BW), .MAX_NONCE(NW'(MAXN))) dut (
    .clk(clk), .reset(reset), .start(start), .num_entradas(num_entradas),
    .rd_ptr(rd_ptr), .bounty(bounty), .core(ifc.master),
    .res_valid(res_valid), .res_idx(res_idx), .res_found(res_found),
    .res_nonce(res_nonce), .busy(busy), .fin(fin)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit found; longint nonce; int cyc; } res_t;
  typedef struct { longint nonce; longint bty; } start_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [BW-1:0] buf_mem [4];
  int            hit_at [4];
  bit            core_en = 0;
  bit            first_pending = 0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  res_t          res_q[$];
  start_t        starts_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bounty <= buf_mem[rd_ptr];

  // Behavioural hash core with random latency and noisy hit while not done.
  initial begin : core_model
    longint n;
    logic [BW-1:0] b;
    int lat;
    ifc.hash_done = 1'b0;
    ifc.hash_hit  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (core_en && ifc.hash_start) begin
        n = ifc.nonce;
        b = ifc.bounty_out;
        if (first_pending) begin
          chk("start_to_hash_start", cyc - start_cyc, 3);
          first_pending = 0;
        end else if (n == 0) begin
          chk("done_to_next_entry_start", cyc - done_cyc, 4);
        end else begin
          chk("done_to_next_hash_start", cyc - done_cyc, 2);
        end
        lat = $urandom_range(1, 3);
        repeat (lat) begin
          @(posedge clk); #1;
          ifc.hash_hit = 1'($urandom_range(0, 1));
        end
        chk("nonce_stable", ifc.nonce, n);
        chk("bounty_stable", ifc.bounty_out, b);
        ifc.hash_done = 1'b1;
        ifc.hash_hit  = (hit_at[rd_ptr] == n);
        done_cyc = cyc;
        @(posedge clk); #1;
        ifc.hash_done = 1'b0;
        ifc.hash_hit  = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (ifc.hash_start) starts_q.push_back('{ifc.nonce, ifc.bounty_out});
      if (res_valid) res_q.push_back('{res_idx, res_found, res_nonce, cyc});
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_ptr"}, rd_ptr, 0);
    chk({tag, "_nonce"}, ifc.nonce, 0);
    chk({tag, "_bounty_out"}, ifc.bounty_out, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_res_nonce"}, res_nonce, 0);
    chk({tag, "_hash_start"}, ifc.hash_start, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_found"}, res_found, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fin"}, fin, 0);
  endtask

  task automatic run(input int n);
    int k, fin_cyc, nstarts;
    bit seen;
    longint rn;
    bit found;
    res_q.delete();
    starts_q.delete();
    first_pending = 1;
    core_en = 1;
    num_entradas = 2'(n);
    start = 1'b1;
    start_cyc = cyc;
    seen = 0;
    fin_cyc = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      tick();
      num_entradas = 2'($urandom);
      if (fin) begin seen = 1; fin_cyc = cyc; end
    end
    chk("fin_reached", seen, 1);
    k = 0;
    for (int e = 0; e <= n; e++) begin
      found = (hit_at[e] <= MAXN);
      rn = found ? hit_at[e] : MAXN;
      for (int j = 0; j <= rn; j++) begin
        if (k < starts_q.size()) begin
          chk($sformatf("start%0d_nonce", k), starts_q[k].nonce, j);
          chk($sformatf("start%0d_bounty", k), starts_q[k].bty, buf_mem[e]);
        end
        k++;
      end
      if (e < res_q.size()) begin
        chk($sformatf("res%0d_idx", e), res_q[e].idx, e);
        chk($sformatf("res%0d_found", e), res_q[e].found, found);
        chk($sformatf("res%0d_nonce", e), res_q[e].nonce, rn);
      end
    end
    chk("hash_start_count", starts_q.size(), k);
    chk("res_count", res_q.size(), n + 1);
    if (res_q.size() > 0) chk("res_to_fin", fin_cyc - res_q[res_q.size()-1].cyc, 1);
    chk("done_rd_ptr", rd_ptr, n);
    chk("done_busy", busy, 0);
    nstarts = starts_q.size();
    repeat (4) tick();
    chk("fin_held", fin, 1);
    chk("no_restart", starts_q.size(), nstarts);
    start = 1'b0;
    tick();
    chk("fin_fall", fin, 0);
    chk("idle_busy", busy, 0);
    tick();
  endtask

  initial begin : main
    reset = 1'b1;
    start = 1'b0;
    num_entradas = 2'd0;
    for (int i = 0; i < 4; i++) begin buf_mem[i] = '0; hit_at[i] = 7; end
    repeat (2) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Abort in WAIT; done injected alongside and after reset must be ignored.
    buf_mem[0] = 24'hABCDEF;
    core_en = 0;
    start = 1'b1;
    for (int t = 0; t < 20 && !ifc.hash_start; t++) tick();
    chk("rst_pre_hash_start", ifc.hash_start, 1);
    tick();
    chk("rst_pre_busy", busy, 1);
    res_q.delete();
    starts_q.delete();
    reset = 1'b1;
    start = 1'b0;
    ifc.hash_done = 1'b1;
    ifc.hash_hit  = 1'b1;
    tick();
    chk_zero("midrst");
    reset = 1'b0;
    tick();
    ifc.hash_done = 1'b0;
    ifc.hash_hit  = 1'b0;
    repeat (4) tick();
    chk("midrst_no_result", res_q.size(), 0);
    chk("midrst_no_start", starts_q.size(), 0);
    chk("midrst_busy", busy, 0);

    buf_mem[0] = 24'h00FFFF; hit_at[0] = 3;
    run(0);
    for (int i = 0; i < 4; i++) begin buf_mem[i] = BW'($urandom); hit_at[i] = 0; end
    run(3);
    hit_at[0] = 7;
    run(0);
    hit_at[0] = MAXN; hit_at[1] = 2;
    run(1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        buf_mem[i] = BW'($urandom);
        hit_at[i] = $urandom_range(0, 7);
      end
      run($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
